// File: rtl/arith_unit_arbiter.sv
// arith_unit_arbiter: round-robin share of one registered arithmetic unit
// between two requesters, with a valid/ready tagged response channel.
//
// Ports:
//   clk, RST (sync, active-high)
//   req{0,1}_valid/_ready/_a/_b/_fun  : requester command channels
//   resp_valid/_ready/_id/_data/_err  : tagged result channel
//   alu_a/_b/_fun/_en, alu_out/_flag  : arithmetic unit interface
//   busy                              : high outside IDLE
//
// Optional build macro ARITH_DIV_ZERO_CHECK_EN: when defined, a divide
// with b=0 is answered directly with an error and never reaches the unit.
module arith_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [1:0]         req0_fun,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [1:0]         req1_fun,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_data,
  output logic               resp_err,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_fun,
  output logic               alu_en,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_flag,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         fun_q, fun_d;
  logic               id_q, id_d;
  logic [2*WIDTH-1:0] data_q, data_d;
  logic               err_q, err_d;

  logic               gnt_vld;
  logic               gnt_id;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [1:0]         sel_fun;

  // Pointer only breaks ties; a lone request always wins.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    sel_a   = gnt_id ? req1_a : req0_a;
    sel_b   = gnt_id ? req1_b : req0_b;
    sel_fun = gnt_id ? req1_fun : req0_fun;
  end

  // Ready is masked by RST so nothing looks accepted on a reset edge.
  assign req0_ready = (state_q == IDLE) & ~RST
                    & gnt_vld & ~gnt_id;
  assign req1_ready = (state_q == IDLE) & ~RST
                    & gnt_vld & gnt_id;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          a_d     = sel_a;
          b_d     = sel_b;
          fun_d   = sel_fun;
          id_d    = gnt_id;
          state_d = ISSUE;
`ifdef ARITH_DIV_ZERO_CHECK_EN
          if (sel_fun == 2'b11 && sel_b == '0) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // A unit that fails to flag its result yields an error
        // response with a zeroed payload.
        data_d  = alu_flag ? alu_out : '0;
        err_d   = ~alu_flag;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          ptr_d   = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_fun    = fun_q;
  assign alu_en     = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_arith_unit_arbiter.sv
// tb_arith_unit_arbiter: directed plus randomized bench for the arbiter,
// checked against a transaction-level model of grants and responses.
module tb_arith_unit_arbiter;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [W-1:0]  req0_a = '0;
  logic [W-1:0]  req0_b = '0;
  logic [1:0]    req0_fun = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [W-1:0]  req1_a = '0;
  logic [W-1:0]  req1_b = '0;
  logic [1:0]    req1_fun = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_id;
  logic [2*W-1:0] resp_data;
  logic          resp_err;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [1:0]    alu_fun;
  logic          alu_en;
  logic [2*W-1:0] alu_out = '0;
  logic          alu_flag = 1'b0;
  logic          busy;

  arith_unit_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .RST        (RST),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_fun   (req0_fun),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_fun   (req1_fun),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fun    (alu_fun),
    .alu_en     (alu_en),
    .alu_out    (alu_out),
    .alu_flag   (alu_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_alu(logic [15:0] a,
                                        logic [15:0] b,
                                        logic [1:0] f);
    logic [31:0] xa, xb;
    xa = {16'b0, a};
    xb = {16'b0, b};
    case (f)
      2'b00:   return xa + xb;
      2'b01:   return xa - xb;
      2'b10:   return xa * xb;
      default: return (b == 0) ? 32'hFFFF_FFFF : xa / xb;
    endcase
  endfunction

  // Unit under the arbiter: registered, flag only after an enable.
  bit kill_op = 1'b0;
  always @(posedge clk) begin
    alu_flag <= alu_en && !kill_op;
    if (alu_en) alu_out <= f_alu(alu_a, alu_b, alu_fun);
  end

  // Transaction model state
  bit          m_pend = 0;
  bit          m_ptr = 0;
  bit          m_after_rst = 0;
  bit          m_dz = 0;
  int          cyc = 0;
  int          m_acc = 0;
  int          m_due = 0;
  bit          e_id;
  logic [15:0] e_a, e_b;
  logic [1:0]  e_fun;
  logic [31:0] e_data;
  bit          e_err;
  bit          force_kill = 0;
  bit          rand_kill = 0;
  bit          id_log[$];
  int          cyc_log[$];

  task automatic step();
    bit g_vld, g_id, rv, en;
    @(negedge clk);
    g_vld = !m_pend && !RST && (req0_valid || req1_valid);
    g_id  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    rv    = m_pend && (cyc >= m_due);
    en    = m_pend && !m_dz && (cyc == m_acc + 1);
    chk("req0_ready", req0_ready, g_vld && !g_id);
    chk("req1_ready", req1_ready, g_vld && g_id);
    chk("busy", busy, m_pend);
    chk("resp_valid", resp_valid, rv);
    chk("alu_en", alu_en, en);
    if (en) begin
      chk("alu_a", alu_a, e_a);
      chk("alu_b", alu_b, e_b);
      chk("alu_fun", alu_fun, e_fun);
    end
    if (rv) begin
      chk("resp_id", resp_id, e_id);
      chk("resp_data", resp_data, e_data);
      chk("resp_err", resp_err, e_err);
    end
    if (m_after_rst) begin
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_fun", alu_fun, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_err", resp_err, 0);
    end
    m_after_rst = 0;
    if (RST) begin
      m_pend = 0;
      m_ptr = 0;
      m_after_rst = 1;
    end else if (rv && resp_ready) begin
      m_pend = 0;
      m_ptr = !e_id;
      id_log.push_back(resp_id);
      cyc_log.push_back(cyc);
    end else if (g_vld) begin
      e_id  = g_id;
      e_a   = g_id ? req1_a : req0_a;
      e_b   = g_id ? req1_b : req0_b;
      e_fun = g_id ? req1_fun : req0_fun;
`ifdef ARITH_DIV_ZERO_CHECK_EN
      m_dz = (e_fun == 2'b11) && (e_b == 0);
`else
      m_dz = 0;
`endif
      kill_op = force_kill ||
                (rand_kill && $urandom_range(0, 9) == 0);
      m_pend = 1;
      m_acc  = cyc;
      m_due  = cyc + (m_dz ? 1 : 3);
      e_err  = m_dz || kill_op;
      e_data = e_err ? 32'h0 : f_alu(e_a, e_b, e_fun);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    bit [3:0] ord;
    @(posedge clk);
    #1;
    // Reset, with both requesters already asserting
    RST = 1'b1;
    step();
    req0_valid = 1;
    req1_valid = 1;
    step();
    req0_valid = 0;
    req1_valid = 0;
    RST = 1'b0;
    step();

    // Single request: 5 + 3
    req0_valid = 1; req0_a = 16'h0005;
    req0_b = 16'h0003; req0_fun = 2'b00;
    resp_ready = 1;
    step();
    req0_valid = 0;
    repeat (5) step();

    // Contention, round-robin from a fresh pointer
    do_reset();
    id_log.delete();
    cyc_log.delete();
    req0_valid = 1; req0_a = 16'h00FF;
    req0_b = 16'h0002; req0_fun = 2'b10;
    req1_valid = 1; req1_a = 16'h0010;
    req1_b = 16'h0004; req1_fun = 2'b01;
    repeat (16) step();
    req0_valid = 0;
    req1_valid = 0;
    repeat (3) step();
    chk("rr_count", id_log.size(), 4);
    if (id_log.size() >= 4) begin
      ord = {id_log[0], id_log[1], id_log[2], id_log[3]};
      chk("rr_order", ord, 4'b0101);
      for (int i = 1; i < 4; i++)
        chk("rr_interval", cyc_log[i] - cyc_log[i-1], 4);
    end

    // Response backpressure, other requester waiting
    resp_ready = 0;
    req0_valid = 1; req0_a = 16'h1234;
    req0_b = 16'h0101; req0_fun = 2'b00;
    step();
    req0_valid = 0;
    req1_valid = 1;
    repeat (8) step();
    resp_ready = 1;
    req1_valid = 0;
    repeat (3) step();

    // Reset in the CAPTURE cycle, then a lone req1
    req0_valid = 1; req0_a = 16'h0007;
    req0_b = 16'h0009; req0_fun = 2'b10;
    step();
    req0_valid = 0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    req1_valid = 1; req1_a = 16'h0030;
    req1_b = 16'h0006; req1_fun = 2'b11;
    step();
    req1_valid = 0;
    repeat (4) step();

    // Unit never flags its result
    force_kill = 1;
    req0_valid = 1; req0_a = 16'h0040;
    req0_b = 16'h0002; req0_fun = 2'b00;
    step();
    req0_valid = 0;
    repeat (4) step();
    force_kill = 0;

    // Divide by zero from req1
    req1_valid = 1; req1_a = 16'h0064;
    req1_b = 16'h0000; req1_fun = 2'b11;
    step();
    req1_valid = 0;
    repeat (4) step();

    // Randomized traffic
    rand_kill = 1;
    for (int i = 0; i < 2000; i++) begin
      RST        = ($urandom_range(0, 199) == 0);
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_a     = 16'($urandom);
      req1_a     = 16'($urandom);
      req0_b     = ($urandom_range(0, 3) == 0) ? 16'h0
                                              : 16'($urandom);
      req1_b     = ($urandom_range(0, 3) == 0) ? 16'h0
                                              : 16'($urandom);
      req0_fun   = 2'($urandom);
      req1_fun   = 2'($urandom);
      resp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    RST = 0;
    req0_valid = 0;
    req1_valid = 0;
    resp_ready = 1;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
